// File: rtl/adpll_cfg_seq.sv
// -----------------------------------------------------------------------------
// adpll_cfg_seq
//
// Bus initiator that brings up the ADPLL register block without CPU help.
// A start pulse runs a fixed write sequence (soft reset high, soft reset low,
// FCW, mode, enable). The sequencer then polls the LOCK register until the
// PLL reports lock or the lock timeout expires.
//
// Optional feature macro: ADPLL_SEQ_SAT_CHECK_EN
//   When defined, a lock is followed by one read of the SAT register.
//   SAT=1 ends the sequence with a fail pulse (locked stays set).
//   SAT=0 ends it with a done pulse.
//   When not defined, lock leads straight to the done pulse.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous reset, active high
//   start     in   1-cycle start pulse, ignored unless idle
//   fcw_cfg   in   FCW to program, sampled at start
//   mode_cfg  in   ADPLL mode to program, sampled at start
//   busy      out  high in every state except IDLE
//   done      out  1-cycle pulse: sequence finished with lock
//   fail      out  1-cycle pulse: lock timeout or saturation seen
//   locked    out  sticky lock status, cleared at start
//   valid     out  bus request
//   address   out  bus address
//   wdata     out  bus write data, unused bits always 0
//   wstrb     out  1 = write, 0 = read
//   ready     in   bus acknowledge from the register slave
//   rdata     in   bus read data, bit 0 = status
// -----------------------------------------------------------------------------

`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 'h00
`endif
`ifndef FCW
`define FCW 'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h08
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h10
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 'h14
`endif

module adpll_cfg_seq #(
    parameter int ADDR_W  = `ADPLL_ADDR_W,
    parameter int DATA_W  = `ADPLL_DATA_W,
    parameter int FCW_W   = `FCWW,
    parameter int LOCK_TO = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FCW_W-1:0]  fcw_cfg,
    input  logic [1:0]        mode_cfg,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              locked,
    output logic              valid,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              wstrb,
    input  logic              ready,
    input  logic [1:0]        rdata
);

    localparam int CNT_W = $clog2(LOCK_TO + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TO);

    localparam logic [ADDR_W-1:0] A_SOFT_RST = ADDR_W'(`ADPLL_SOFT_RST);
    localparam logic [ADDR_W-1:0] A_FCW      = ADDR_W'(`FCW);
    localparam logic [ADDR_W-1:0] A_MODE     = ADDR_W'(`ADPLL_MODE);
    localparam logic [ADDR_W-1:0] A_EN       = ADDR_W'(`ADPLL_EN);
    localparam logic [ADDR_W-1:0] A_LOCK     = ADDR_W'(`ADPLL_LOCK);
`ifdef ADPLL_SEQ_SAT_CHECK_EN
    localparam logic [ADDR_W-1:0] A_SAT      = ADDR_W'(`ADPLL_SAT);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_RST1,
        S_W_RST0,
        S_W_FCW,
        S_W_MODE,
        S_W_EN,
        S_R_LOCK,
`ifdef ADPLL_SEQ_SAT_CHECK_EN
        S_R_SAT,
`endif
        S_DONE,
        S_FAIL
    } state_t;

    // Handshake: every bus state has two phases.
    //   REQ (rel_q=0): valid=1, address/wdata/wstrb frozen until ready=1 is
    //                  sampled; rdata is taken in that same cycle for reads.
    //   REL (rel_q=1): valid=0 until ready=0 is sampled. The slave's ready
    //                  lags valid, so waiting here keeps a stale ready from
    //                  acknowledging the next request.
    state_t             state_q, state_d;
    logic               rel_q, rel_d;
    logic               hit_q, hit_d;       // status bit of the last read
    logic               locked_q, locked_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wstrb_q, wstrb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic [1:0]         mode_q, mode_d;

    logic               issue;
    state_t             issue_st;

    logic               unused_rdata;
    assign unused_rdata = rdata[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rel_q    <= 1'b0;
            hit_q    <= 1'b0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 1'b0;
            cnt_q    <= '0;
            fcw_q    <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            rel_q    <= rel_d;
            hit_q    <= hit_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            cnt_q    <= cnt_d;
            fcw_q    <= fcw_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rel_d    = rel_q;
        hit_d    = hit_q;
        locked_d = locked_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        cnt_d    = cnt_q;
        fcw_d    = fcw_q;
        mode_d   = mode_q;
        issue    = 1'b0;
        issue_st = S_IDLE;

        // Lock timeout runs for the whole polling phase and saturates.
        if (state_q == S_R_LOCK && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fcw_d    = fcw_cfg;
                    mode_d   = mode_cfg;
                    locked_d = 1'b0;
                    issue    = 1'b1;
                    issue_st = S_W_RST1;
                end
            end

            S_DONE, S_FAIL: begin
                state_d = S_IDLE;
            end

            default: begin
                if (!rel_q) begin
                    if (ready) begin
                        valid_d = 1'b0;
                        rel_d   = 1'b1;
                        if (state_q == S_R_LOCK) begin
                            hit_d = rdata[0];
                            if (rdata[0]) begin
                                locked_d = 1'b1;
                            end
                        end
`ifdef ADPLL_SEQ_SAT_CHECK_EN
                        if (state_q == S_R_SAT) begin
                            hit_d = rdata[0];
                        end
`endif
                    end
                end else if (!ready) begin
                    rel_d = 1'b0;
                    case (state_q)
                        S_W_RST1: begin
                            issue    = 1'b1;
                            issue_st = S_W_RST0;
                        end
                        S_W_RST0: begin
                            issue    = 1'b1;
                            issue_st = S_W_FCW;
                        end
                        S_W_FCW: begin
                            issue    = 1'b1;
                            issue_st = S_W_MODE;
                        end
                        S_W_MODE: begin
                            issue    = 1'b1;
                            issue_st = S_W_EN;
                        end
                        S_W_EN: begin
                            // First LOCK request: timeout starts from 0 here.
                            cnt_d    = '0;
                            issue    = 1'b1;
                            issue_st = S_R_LOCK;
                        end
                        S_R_LOCK: begin
                            // A lock seen on the last read beats the timeout.
                            if (hit_q) begin
`ifdef ADPLL_SEQ_SAT_CHECK_EN
                                issue    = 1'b1;
                                issue_st = S_R_SAT;
`else
                                state_d  = S_DONE;
                                addr_d   = '0;
                                wdata_d  = '0;
                                wstrb_d  = 1'b0;
`endif
                            end else if (cnt_q == CNT_MAX) begin
                                state_d = S_FAIL;
                                addr_d  = '0;
                                wdata_d = '0;
                                wstrb_d = 1'b0;
                            end else begin
                                issue    = 1'b1;
                                issue_st = S_R_LOCK;
                            end
                        end
`ifdef ADPLL_SEQ_SAT_CHECK_EN
                        S_R_SAT: begin
                            state_d = hit_q ? S_FAIL : S_DONE;
                            addr_d  = '0;
                            wdata_d = '0;
                            wstrb_d = 1'b0;
                        end
`endif
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase

        // Launch the REQ phase of the next bus state.
        if (issue) begin
            state_d = issue_st;
            rel_d   = 1'b0;
            hit_d   = 1'b0;
            valid_d = 1'b1;
            wstrb_d = 1'b1;
            addr_d  = '0;
            wdata_d = '0;
            case (issue_st)
                S_W_RST1: begin
                    addr_d  = A_SOFT_RST;
                    wdata_d = DATA_W'(1);
                end
                S_W_RST0: begin
                    addr_d  = A_SOFT_RST;
                end
                S_W_FCW: begin
                    addr_d  = A_FCW;
                    wdata_d = DATA_W'(fcw_q);
                end
                S_W_MODE: begin
                    addr_d  = A_MODE;
                    wdata_d = DATA_W'(mode_q);
                end
                S_W_EN: begin
                    addr_d  = A_EN;
                    wdata_d = DATA_W'(1);
                end
                S_R_LOCK: begin
                    addr_d  = A_LOCK;
                    wstrb_d = 1'b0;
                end
`ifdef ADPLL_SEQ_SAT_CHECK_EN
                S_R_SAT: begin
                    addr_d  = A_SAT;
                    wstrb_d = 1'b0;
                end
`endif
                default: begin
                    valid_d = 1'b0;
                    wstrb_d = 1'b0;
                end
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign fail    = (state_q == S_FAIL);
    assign locked  = locked_q;
    assign valid   = valid_q;
    assign address = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;

endmodule

// File: tb/tb_adpll_cfg_seq.sv
module tb_adpll_cfg_seq;

    localparam int LOCK_TO = 64;
    localparam logic [7:0] A_SOFT = 8'h00;
    localparam logic [7:0] A_FCW  = 8'h04;
    localparam logic [7:0] A_MODE = 8'h08;
    localparam logic [7:0] A_EN   = 8'h0C;
    localparam logic [7:0] A_LOCK = 8'h10;
    localparam logic [7:0] A_SAT  = 8'h14;
`ifdef ADPLL_SEQ_SAT_CHECK_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [25:0] fcw_cfg;
    logic [1:0]  mode_cfg;
    logic        busy, done, fail, locked;
    logic        valid;
    logic [7:0]  address;
    logic [31:0] wdata;
    logic        wstrb;
    logic        ready;
    logic [1:0]  rdata;

    adpll_cfg_seq #(.LOCK_TO(LOCK_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .fcw_cfg(fcw_cfg), .mode_cfg(mode_cfg),
        .busy(busy), .done(done), .fail(fail), .locked(locked),
        .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .rdata(rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [40:0] exp_q[$];
    logic [40:0] act_q[$];
    int stab_err = 0;
    int stale_err = 0;
    int first_lock_cyc = -1;

    // slave model knobs
    int   dly_v = 1;
    int   lock_at_v = 0;
    logic sat_v = 1'b0;
    int   lock_rd = 0;
    int   s_cnt = 0;
    logic prev_valid = 1'b0;
    logic [40:0] prev_bus = '0;

    // Monitor first, then the slave: ready follows valid after dly_v negedges.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            act_q.push_back({address, wdata, wstrb});
            if (ready) stale_err++;
            if (address == A_LOCK && first_lock_cyc < 0) first_lock_cyc = cyc;
        end
        if (valid && prev_valid && ({address, wdata, wstrb} != prev_bus)) stab_err++;
        prev_valid = valid;
        prev_bus   = {address, wdata, wstrb};

        if (rst) begin
            ready = 1'b0;
            rdata = 2'b11;
            s_cnt = 0;
        end else if (valid != ready) begin
            s_cnt++;
            if (s_cnt >= dly_v) begin
                s_cnt = 0;
                ready = valid;
                if (valid && !wstrb && address == A_LOCK) begin
                    lock_rd++;
                    rdata = {1'b1, (lock_at_v != 0 && lock_rd >= lock_at_v)};
                end else if (valid && !wstrb && address == A_SAT) begin
                    rdata = {1'b1, sat_v};
                end else begin
                    // Garbage outside the read-sampling cycle must be ignored.
                    rdata = 2'b11;
                end
            end
        end else begin
            s_cnt = 0;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_expected(input logic [25:0] f, input logic [1:0] m,
                                  input int n_lock, input bit sat_read);
        exp_q.delete();
        exp_q.push_back({A_SOFT, 32'd1, 1'b1});
        exp_q.push_back({A_SOFT, 32'd0, 1'b1});
        exp_q.push_back({A_FCW, {6'd0, f}, 1'b1});
        exp_q.push_back({A_MODE, {30'd0, m}, 1'b1});
        exp_q.push_back({A_EN, 32'd1, 1'b1});
        for (int k = 0; k < n_lock; k++) exp_q.push_back({A_LOCK, 32'd0, 1'b0});
        if (sat_read) exp_q.push_back({A_SAT, 32'd0, 1'b0});
    endtask

    task automatic compare_log(input string tag, input bit exact_len);
        int n;
        if (exact_len) check({tag, "_log_len"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_op%0d", tag, k), act_q[k], exp_q[k]);
    endtask

    task automatic wait_end(input string tag, output logic got_done, output logic got_fail);
        int n = 0;
        while (!(done || fail) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, done | fail, 1);
        got_done = done;
        got_fail = fail;
    endtask

    task automatic run_vec(input string tag, input logic [25:0] f, input logic [1:0] m,
                           input int lock_at, input logic sat, input int dly,
                           output logic got_done, output logic got_fail, output int t_end);
        dly_v = dly;
        lock_at_v = lock_at;
        sat_v = sat;
        lock_rd = 0;
        act_q.delete();
        first_lock_cyc = -1;
        @(negedge clk);
        fcw_cfg = f;
        mode_cfg = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fcw_cfg = 26'($urandom);
        mode_cfg = 2'($urandom_range(0, 3));
        check({tag, "_busy_after_start"}, busy, 1);
        wait_end(tag, got_done, got_fail);
        t_end = cyc;
        @(negedge clk);
        check({tag, "_pulse_end"}, {done, fail, busy, valid}, 4'b0000);
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [25:0] fcw;
        logic [1:0]  mode;
        int          lock_at;   // 0 = never locks
        int          dly;
        logic        exp_done;
        logic        exp_fail;
        logic        exp_locked;
    } vec_t;
    vec_t vecs[5];

    logic got_done, got_fail;
    int   t_end;
    int   bad_tail;

    initial begin
        vecs[0] = '{26'h2620000, 2'd2, 3, 1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{26'h3ffffff, 2'd3, 1, 1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{26'h0000000, 2'd0, 2, 5, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{26'h1555555, 2'd1, 0, 1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{26'h0000001, 2'd2, 4, 3, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        fcw_cfg = '0;
        mode_cfg = '0;
        repeat (3) @(negedge clk);
        check("reset_status", {busy, done, fail, locked}, 4'b0000);
        check("reset_bus", {valid, address, wdata, wstrb}, 42'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_vec(tag, vecs[i].fcw, vecs[i].mode, vecs[i].lock_at, 1'b0, vecs[i].dly,
                    got_done, got_fail, t_end);
            check({tag, "_done"}, got_done, vecs[i].exp_done);
            check({tag, "_fail"}, got_fail, vecs[i].exp_fail);
            check({tag, "_locked"}, locked, vecs[i].exp_locked);
            if (vecs[i].lock_at != 0) begin
                build_expected(vecs[i].fcw, vecs[i].mode, vecs[i].lock_at, SAT_EN);
                compare_log(tag, 1'b1);
            end else begin
                build_expected(vecs[i].fcw, vecs[i].mode, 0, 1'b0);
                compare_log(tag, 1'b0);
                bad_tail = 0;
                for (int k = 5; k < act_q.size(); k++)
                    if (act_q[k] != {A_LOCK, 32'd0, 1'b0}) bad_tail++;
                check({tag, "_tail_lock_reads"}, bad_tail, 0);
                check({tag, "_has_lock_read"}, act_q.size() > 5, 1);
                check({tag, "_timeout_window"},
                      (t_end - first_lock_cyc >= LOCK_TO) && (t_end - first_lock_cyc <= LOCK_TO + 8), 1);
            end
        end

        // Starts while busy and in the DONE cycle are ignored.
        dly_v = 1;
        lock_at_v = 2;
        lock_rd = 0;
        act_q.delete();
        @(negedge clk);
        fcw_cfg = 26'h0abcdef;
        mode_cfg = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        fcw_cfg = 26'h3333333;
        mode_cfg = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("t4", got_done, got_fail);
        check("t4_done", got_done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_idle_after_done_start", {busy, valid}, 2'b00);
        repeat (6) @(negedge clk);
        check("t4_still_idle", busy, 0);
        build_expected(26'h0abcdef, 2'd1, 2, SAT_EN);
        compare_log("t4", 1'b1);

        // Async reset in the middle of the FCW write.
        lock_at_v = 0;
        act_q.delete();
        @(negedge clk);
        fcw_cfg = 26'h1234567;
        mode_cfg = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100 && !(valid && address == A_FCW); n++) @(negedge clk);
        check("t5_reached_fcw", {valid, address}, {1'b1, A_FCW});
        rst = 1'b1;
        #1;
        check("t5_rst_status", {busy, done, fail, locked}, 4'b0000);
        check("t5_rst_bus", {valid, address, wdata, wstrb}, 42'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("t5_restart", 26'h2000001, 2'd3, 2, 1'b0, 1, got_done, got_fail, t_end);
        check("t5_restart_done", got_done, 1);
        build_expected(26'h2000001, 2'd3, 2, SAT_EN);
        compare_log("t5_restart", 1'b1);

`ifdef ADPLL_SEQ_SAT_CHECK_EN
        run_vec("t6_sat1", 26'h0123456, 2'd2, 1, 1'b1, 1, got_done, got_fail, t_end);
        check("t6_sat1_fail", {got_done, got_fail}, 2'b01);
        check("t6_sat1_locked", locked, 1);
        build_expected(26'h0123456, 2'd2, 1, 1'b1);
        compare_log("t6_sat1", 1'b1);
        run_vec("t6_sat0", 26'h0654321, 2'd1, 1, 1'b0, 1, got_done, got_fail, t_end);
        check("t6_sat0_done", {got_done, got_fail}, 2'b10);
        check("t6_sat0_locked", locked, 1);
        build_expected(26'h0654321, 2'd1, 1, 1'b1);
        compare_log("t6_sat0", 1'b1);
`endif

        check("bus_stable_during_req", stab_err, 0);
        check("no_req_on_stale_ready", stale_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
